// File: rtl/spectrum_pkg.sv
// Shared sizes, FSM state type and the 256-bit lane helper for the spectrum peak smoother.
package spectrum_pkg;

  localparam int NUM_BINS = 16;
  localparam int BIN_W    = 16;
  localparam int MAG_W    = BIN_W - 1;
  localparam int CNT_W    = 4;
  localparam int BUS_W    = NUM_BINS * BIN_W;
  localparam int IDX_W    = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PROC    = 2'd1,
    PUBLISH = 2'd2
  } state_e;

  // Lane k of a packed bus sits at [16k+15:16k].
  function automatic logic [BIN_W-1:0] lane_get(input logic [BUS_W-1:0] bus,
                                                input logic [IDX_W-1:0] k);
    return bus[BIN_W*k +: BIN_W];
  endfunction

endpackage

// File: rtl/peak_decay_cell.sv
// Combinational per-bin update: saturated magnitude, peak capture, hold countdown and decay.
module peak_decay_cell
  import spectrum_pkg::*;
#(
  parameter int DECAY_SHIFT = 3,
  parameter int HOLD_FRAMES = 2
) (
  input  logic signed [BIN_W-1:0] bin_i,
  input  logic        [MAG_W-1:0] held_i,
  input  logic        [CNT_W-1:0] hold_cnt_i,
  output logic        [MAG_W-1:0] held_o,
  output logic        [CNT_W-1:0] hold_cnt_o
);

  localparam logic [BIN_W-1:0] MOST_NEG = {1'b1, {MAG_W{1'b0}}};

  logic [MAG_W-1:0] mag;
  logic [MAG_W-1:0] step;
  logic [MAG_W-1:0] decayed;

  always_comb begin
    // -32768 has no positive twin in 16 bits, so it saturates to full scale.
    if (bin_i == MOST_NEG) begin
      mag = {MAG_W{1'b1}};
    end else if (bin_i[BIN_W-1]) begin
      mag = MAG_W'(-bin_i);
    end else begin
      mag = bin_i[MAG_W-1:0];
    end

    step = held_i >> DECAY_SHIFT;
    if (step == '0) begin
      step = MAG_W'(1);
    end
    decayed = held_i - step;

    held_o     = held_i;
    hold_cnt_o = hold_cnt_i;
    if (mag >= held_i) begin
      held_o     = mag;
      hold_cnt_o = CNT_W'(HOLD_FRAMES);
    end else if (hold_cnt_i != '0) begin
      hold_cnt_o = hold_cnt_i - CNT_W'(1);
    end else begin
      // Only reached with held_i > mag >= 0, so step <= held_i and no wrap occurs.
      held_o = (decayed > mag) ? decayed : mag;
    end
  end

endmodule

// File: rtl/spectrum_peak_smoother.sv
// Serial per-bin peak-hold/decay smoother between the FFT magnitude stage and the video display.
module spectrum_peak_smoother
  import spectrum_pkg::*;
#(
  parameter int DECAY_SHIFT = 3,
  parameter int HOLD_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             done_in,
  input  logic [BUS_W-1:0] bins_in,
  output logic [BUS_W-1:0] bins_out,
  output logic             done_out,
  output logic             busy,
  output logic             overrun,
  output state_e           state_dbg_o
);

  // Handshake: done_in and done_out are one-cycle strobes with no backpressure; a done_in
  // that arrives while busy is dropped and reported by a one-cycle overrun pulse.

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BINS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BUS_W-1:0] buf_q, buf_d;
  logic [BUS_W-1:0] bins_out_q, bins_out_d;
  logic             overrun_q, overrun_d;
  logic [MAG_W-1:0] held_q [NUM_BINS];
  logic [MAG_W-1:0] held_d [NUM_BINS];
  logic [CNT_W-1:0] cnt_q  [NUM_BINS];
  logic [CNT_W-1:0] cnt_d  [NUM_BINS];

  logic [MAG_W-1:0] cell_held;
  logic [CNT_W-1:0] cell_cnt;

  peak_decay_cell #(
    .DECAY_SHIFT (DECAY_SHIFT),
    .HOLD_FRAMES (HOLD_FRAMES)
  ) u_cell (
    .bin_i      (lane_get(buf_q, idx_q)),
    .held_i     (held_q[idx_q]),
    .hold_cnt_i (cnt_q[idx_q]),
    .held_o     (cell_held),
    .hold_cnt_o (cell_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      buf_q      <= '0;
      bins_out_q <= '0;
      overrun_q  <= 1'b0;
      held_q     <= '{default: '0};
      cnt_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      buf_q      <= buf_d;
      bins_out_q <= bins_out_d;
      overrun_q  <= overrun_d;
      held_q     <= held_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (done_in) state_d = PROC;
      PROC:    if (idx_q == LAST_IDX) state_d = PUBLISH;
      PUBLISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d      = idx_q;
    buf_d      = buf_q;
    bins_out_d = bins_out_q;
    held_d     = held_q;
    cnt_d      = cnt_q;
    overrun_d  = done_in && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (done_in) buf_d = bins_in;
      end
      PROC: begin
        held_d[idx_q] = cell_held;
        cnt_d[idx_q]  = cell_cnt;
        idx_d         = idx_q + IDX_W'(1);
        // Snapshot from held_d so the last bin lands together with all the others.
        if (idx_q == LAST_IDX) begin
          for (int k = 0; k < NUM_BINS; k++) begin
            bins_out_d[BIN_W*k +: BIN_W] = {1'b0, held_d[k]};
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy        = (state_q != IDLE);
    done_out    = (state_q == PUBLISH);
    bins_out    = bins_out_q;
    overrun     = overrun_q;
    state_dbg_o = state_q;
  end

endmodule

// File: tb/tb_spectrum_peak_smoother.sv
// Bench for spectrum_peak_smoother: frame table, scoreboard against an integer model, corner sequences.
module tb_spectrum_peak_smoother;
  import spectrum_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         done_in;
  logic [255:0] bins_in;
  logic [255:0] bins_out;
  logic         done_out;
  logic         busy;
  logic         overrun;
  state_e       state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [255:0] exp_q[$];
  int m_held[16];
  int m_cnt[16];

  typedef struct {
    logic [15:0] b0, b3, b4, b7;
    logic [14:0] e0, e3, e4, e7;
  } vec_t;
  vec_t vecs[9];

  always #5 clk = ~clk;

  spectrum_peak_smoother #(.DECAY_SHIFT(3), .HOLD_FRAMES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .done_in     (done_in),
    .bins_in     (bins_in),
    .bins_out    (bins_out),
    .done_out    (done_out),
    .busy        (busy),
    .overrun     (overrun),
    .state_dbg_o (state_dbg)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) begin
      m_held[k] = 0;
      m_cnt[k]  = 0;
    end
  endtask

  task automatic model_frame(input logic [255:0] b, output logic [255:0] e);
    logic signed [15:0] v;
    int mag, step;
    e = '0;
    for (int k = 0; k < 16; k++) begin
      v   = b[16*k +: 16];
      mag = (v < 0) ? -int'(v) : int'(v);
      if (mag > 32767) mag = 32767;
      if (mag >= m_held[k]) begin
        m_held[k] = mag;
        m_cnt[k]  = 2;
      end else if (m_cnt[k] > 0) begin
        m_cnt[k] = m_cnt[k] - 1;
      end else begin
        step = m_held[k] / 8;
        if (step < 1) step = 1;
        m_held[k] = m_held[k] - step;
        if (m_held[k] < mag) m_held[k] = mag;
      end
      e[16*k +: 16] = 16'(m_held[k]);
    end
  endtask

  function automatic logic [255:0] rand_bins();
    logic [255:0] b;
    for (int w = 0; w < 8; w++) b[32*w +: 32] = $urandom;
    return b;
  endfunction

  // Scoreboard: every done_out pops one expected frame.
  always @(negedge clk) begin
    logic [255:0] e;
    logic any15;
    if (done_out) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got done_out=1 expected no pending frame");
      end else begin
        e = exp_q.pop_front();
        chk("frame_bins", bins_out, e);
      end
      any15 = 1'b0;
      for (int k = 0; k < 16; k++) any15 = any15 | bins_out[16*k+15];
      chk_int("lane_bit15", int'(any15), 0);
    end
  end

  task automatic run_frame(input logic [255:0] b, input int ovr_at, input string tag);
    logic [255:0] e;
    int done_at, done_cnt, busy_cnt, ovr_cnt;
    done_at = 0; done_cnt = 0; busy_cnt = 0; ovr_cnt = 0;
    @(posedge clk); #1;
    done_in = 1'b1;
    bins_in = b;
    model_frame(b, e);
    exp_q.push_back(e);
    @(posedge clk); #1;
    done_in = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done_out) begin
        done_cnt++;
        if (done_at == 0) done_at = n;
      end
      if (busy) busy_cnt++;
      if (overrun) ovr_cnt++;
      if (ovr_at != 0 && n == ovr_at) begin
        done_in = 1'b1;
        bins_in = ~b;
      end else begin
        done_in = 1'b0;
      end
    end
    chk_int({tag, "_latency"}, done_at, 17);
    chk_int({tag, "_done_count"}, done_cnt, 1);
    chk_int({tag, "_busy_cycles"}, busy_cnt, 17);
    chk_int({tag, "_overrun_pulses"}, ovr_cnt, (ovr_at != 0) ? 1 : 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] b;
    int dcnt;

    vecs[0] = '{16'd16000, 16'h8000, 16'hFF9C, 16'd5, 15'd16000, 15'd32767, 15'd100, 15'd5};
    vecs[1] = '{16'd0, 16'd0, 16'd0, 16'd0, 15'd16000, 15'd32767, 15'd100, 15'd5};
    vecs[2] = '{16'd0, 16'd0, 16'd0, 16'd0, 15'd16000, 15'd32767, 15'd100, 15'd5};
    vecs[3] = '{16'd0, 16'd0, 16'd0, 16'd0, 15'd14000, 15'd28672, 15'd88, 15'd4};
    vecs[4] = '{16'd0, 16'd0, 16'd0, 16'd0, 15'd12250, 15'd25088, 15'd77, 15'd3};
    vecs[5] = '{16'd12250, 16'd0, 16'd0, 16'd0, 15'd12250, 15'd21952, 15'd68, 15'd2};
    vecs[6] = '{16'd0, 16'd0, 16'd0, 16'd0, 15'd12250, 15'd19208, 15'd60, 15'd1};
    vecs[7] = '{16'd0, 16'd0, 16'd0, 16'd0, 15'd12250, 15'd16807, 15'd53, 15'd0};
    vecs[8] = '{16'd0, 16'd32767, 16'd0, 16'd0, 15'd10719, 15'd32767, 15'd47, 15'd0};

    rst = 1'b1;
    done_in = 1'b0;
    bins_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    @(negedge clk);
    chk("reset_bins_out", bins_out, '0);
    chk_int("reset_done_out", int'(done_out), 0);
    chk_int("reset_busy", int'(busy), 0);
    chk_int("reset_overrun", int'(overrun), 0);
    chk_int("reset_state", int'(state_dbg), int'(IDLE));

    run_frame('0, 0, "zero");
    chk("zero_bins_out", bins_out, '0);

    for (int i = 0; i < 9; i++) begin
      b = rand_bins();
      b[15:0]    = vecs[i].b0;
      b[63:48]   = vecs[i].b3;
      b[79:64]   = vecs[i].b4;
      b[127:112] = vecs[i].b7;
      run_frame(b, 0, $sformatf("vec%0d", i));
      chk_int($sformatf("vec%0d_lane0", i), int'(bins_out[15:0]), int'(vecs[i].e0));
      chk_int($sformatf("vec%0d_lane3", i), int'(bins_out[63:48]), int'(vecs[i].e3));
      chk_int($sformatf("vec%0d_lane4", i), int'(bins_out[79:64]), int'(vecs[i].e4));
      chk_int($sformatf("vec%0d_lane7", i), int'(bins_out[127:112]), int'(vecs[i].e7));
    end

    // Second done_in five cycles into a frame must be dropped.
    run_frame(rand_bins(), 5, "ovr");

    // Reset in the middle of a frame aborts it.
    @(posedge clk); #1;
    done_in = 1'b1;
    bins_in = rand_bins();
    @(posedge clk); #1;
    done_in = 1'b0;
    dcnt = 0;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      if (done_out) dcnt++;
      if (n == 8) rst = 1'b1;
      else if (n == 9) rst = 1'b0;
    end
    model_reset();
    chk_int("abort_done_count", dcnt, 0);
    chk("abort_bins_out", bins_out, '0);
    chk_int("abort_busy", int'(busy), 0);

    // Reset wins over a simultaneous done_in.
    @(posedge clk); #1;
    rst = 1'b1;
    done_in = 1'b1;
    bins_in = rand_bins();
    @(posedge clk); #1;
    rst = 1'b0;
    done_in = 1'b0;
    @(negedge clk);
    chk_int("rst_vs_done_busy", int'(busy), 0);
    chk_int("rst_vs_done_state", int'(state_dbg), int'(IDLE));

    b = rand_bins();
    b[15:0] = 16'd16000;
    run_frame(b, 0, "post_reset");
    chk_int("post_reset_lane0", int'(bins_out[15:0]), 16000);

    for (int i = 0; i < 3; i++) run_frame(rand_bins(), 0, $sformatf("rand%0d", i));

    repeat (3) @(negedge clk);
    chk_int("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
